mem_read_engine: RTL

Read-side companion to the memory arbiter's write path: accepts a burst read request (start address, beat count), issues READ commands on the DDR controller app interface, and returns the 256-bit read beats to a consumer over a valid/ready stream. It sits in the `clk_ram` domain between the MIG app port and the capture readback / host export logic. A credit scheme guarantees the controller's unstallable read-return data never overflows the internal FIFO.

---
 rtl/mem_read_engine.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_read_engine.sv
// Burst read engine for the DDR controller app port: issues credit-limited READ
// commands and streams the returned 256-bit beats through a FWFT FIFO.
module mem_read_engine #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_STEP  = 8
) (
  input  logic         clk_ram,
  input  logic         rst_n,
  input  logic         req_en,
  input  logic [28:0]  req_addr,
  input  logic [15:0]  req_len,
  output logic         req_busy,
  output logic         done,
  output logic [28:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  input  logic [255:0] app_rd_data,
  input  logic         app_rd_data_valid,
  input  logic         app_rd_data_end,
  output logic [255:0] rd_data,
  output logic         rd_valid,
  output logic         rd_last,
  input  logic         rd_ready,
  output logic         rd_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  CMD_READ = 3'b001;

  typedef logic [AW:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t r_state, w_next;

  logic [255:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  cnt_t          r_count, r_pending;
  logic [28:0]   r_app_addr, r_next_addr;
  logic          r_app_en, r_overflow;
  logic [15:0]   r_len, r_cmd_cnt, r_pop_cnt;

  logic          w_full, w_pop, w_wr, w_ret_dec, w_ovf_set;
  logic          w_accept, w_slot_free, w_present, w_credit, w_pop_last, w_start;
  logic [AW+1:0] w_used;
  logic [28:0]   w_cmd_addr;
  logic          w_unused;

  assign w_unused = app_rd_data_end;

  assign w_full     = (r_count == DEPTH_C);
  assign w_pop      = (r_count != '0) && rd_ready;
  assign w_ret_dec  = app_rd_data_valid && (r_pending != '0);
  assign w_wr       = w_ret_dec && !w_full;
  assign w_ovf_set  = app_rd_data_valid && w_full;
  assign w_accept   = r_app_en && app_rdy;
  assign w_slot_free = !r_app_en || app_rdy;
  assign w_start    = (r_state == S_IDLE) && req_en;
  assign w_pop_last = (({1'b0, r_pop_cnt} + 17'd1) == {1'b0, r_len});

  // A pop in this cycle frees its slot early so the next command can follow it directly.
  assign w_used   = {1'b0, r_pending} + {1'b0, r_count} - {{(AW+1){1'b0}}, w_pop};
  assign w_credit = (w_used < {1'b0, DEPTH_C});

  assign w_cmd_addr = (r_state == S_IDLE) ? req_addr : r_next_addr;

  always_comb begin
    w_present = 1'b0;
    case (r_state)
      S_IDLE:  w_present = req_en && (req_len != '0) && w_credit;
      S_ISSUE: w_present = w_slot_free && (r_cmd_cnt < r_len) && w_credit;
      default: w_present = 1'b0;
    endcase
  end

  always_ff @(posedge clk_ram) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Zero-length requests also pass through ISSUE for one cycle, so done lands
  // two cycles after req_en like every other completion path expects.
  always_comb begin
    w_next   = r_state;
    done     = 1'b0;
    req_busy = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_busy = 1'b0;
        if (req_en) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_len == '0)
          w_next = S_FINISH;
        else if ((r_cmd_cnt == r_len) && w_slot_free)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_pop_cnt == r_len) || (w_pop && w_pop_last))
          w_next = S_FINISH;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ram) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_cmd_cnt   <= '0;
      r_pop_cnt   <= '0;
      r_app_en    <= 1'b0;
      r_app_addr  <= '0;
      r_next_addr <= '0;
      r_pending   <= '0;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_start) begin
        r_len     <= req_len;
        r_pop_cnt <= '0;
        r_cmd_cnt <= 16'(w_present);
      end else begin
        if (w_pop)     r_pop_cnt <= r_pop_cnt + 16'd1;
        if (w_present) r_cmd_cnt <= r_cmd_cnt + 16'd1;
      end

      if (w_present) begin
        r_app_en    <= 1'b1;
        r_app_addr  <= w_cmd_addr;
        r_next_addr <= w_cmd_addr + 29'(ADDR_STEP);
      end else if (w_accept) begin
        r_app_en <= 1'b0;
      end

      r_pending <= r_pending + cnt_t'(w_present) - cnt_t'(w_ret_dec);
      r_count   <= r_count + cnt_t'(w_wr) - cnt_t'(w_pop);
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_ram) begin
    if (w_wr) r_mem[r_wr_ptr] <= app_rd_data;
  end

  assign app_en      = r_app_en;
  assign app_addr    = r_app_addr;
  assign app_cmd     = r_app_en ? CMD_READ : 3'b000;
  assign rd_data     = r_mem[r_rd_ptr];
  assign rd_valid    = (r_count != '0);
  assign rd_last     = rd_valid && w_pop_last &&
                       ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign rd_overflow = r_overflow;

endmodule
